// File: rtl/draw_seq_if.sv
// draw_seq_if: renderer channels, control handshake and VGA pixel port of draw_sequencer
interface draw_seq_if #(
    parameter int NUM_SRC  = 3,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 6,
    parameter int AS_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic                         init;
    logic                         idle;
    logic [NUM_SRC-1:0]           src_draw;
    logic [NUM_SRC-1:0]           src_done;
    logic [NUM_SRC-1:0]           src_write;
    logic [NUM_SRC*X_W-1:0]       src_x;
    logic [NUM_SRC*Y_W-1:0]       src_y;
    logic [NUM_SRC*COLOUR_W-1:0]  src_colour;
    logic [X_W-1:0]               x_position;
    logic [Y_W-1:0]               y_position;
    logic [COLOUR_W-1:0]          colour;
    logic                         VGA_enable;
    logic [AS_W-1:0]              active_src;
    logic                         idle_done;
    logic                         frame_overrun;
    logic [15:0]                  frame_miss_count;

    modport master (
        output init, idle, src_draw, src_done, src_write, src_x, src_y, src_colour,
        input  x_position, y_position, colour, VGA_enable, active_src,
               idle_done, frame_overrun, frame_miss_count
    );
    modport slave (
        input  init, idle, src_draw, src_done, src_write, src_x, src_y, src_colour,
        output x_position, y_position, colour, VGA_enable, active_src,
               idle_done, frame_overrun, frame_miss_count
    );
endinterface

// File: rtl/draw_sequencer.sv
// draw_sequencer: priority draw-channel mux onto the VGA port plus frame pacer
// Optional missed-frame counter enabled by DRAW_SEQ_STATS_EN.
module draw_sequencer #(
    parameter int NUM_SRC     = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int COLOUR_W    = 6,
    parameter int FRAME_COUNT = 833333,
    parameter int CNT_W       = 24
) (
    input logic clock,
    input logic reset,
    draw_seq_if.slave bus
);
    localparam int AS_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_COUNT - 1);

    typedef enum logic {S_WAIT, S_PEND} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                en_q, en_d;
    logic [AS_W-1:0]     as_q, as_d;
    logic                idle_done_q, idle_done_d;
    logic                overrun_q, overrun_d;
    logic                tick;

    // Scan from the top so the lowest eligible index wins.
    always_comb begin
        x_d = '0;
        y_d = '0;
        colour_d = '0;
        en_d = 1'b0;
        as_d = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.src_draw[i] && !bus.src_done[i]) begin
                x_d = bus.src_x[i*X_W +: X_W];
                y_d = bus.src_y[i*Y_W +: Y_W];
                colour_d = bus.src_colour[i*COLOUR_W +: COLOUR_W];
                en_d = bus.src_write[i];
                as_d = AS_W'(i);
            end
        end
    end

    assign tick  = cnt_q == LAST;
    assign cnt_d = (bus.init || tick) ? '0 : cnt_q + 1'b1;

    // The idle_done_q guard keeps back-to-back pulses apart when PEND exits
    // one cycle before a WAIT tick.
    always_comb begin
        state_d = state_q;
        idle_done_d = 1'b0;
        overrun_d = 1'b0;
        if (bus.init) state_d = S_WAIT;
        else if (state_q == S_WAIT) begin
            state_d = (tick && !bus.idle) ? S_PEND : S_WAIT;
            idle_done_d = tick && bus.idle && !idle_done_q;
        end else if (bus.idle) begin
            state_d = S_WAIT;
            idle_done_d = !idle_done_q;
        end else overrun_d = tick;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_WAIT;
            cnt_q <= '0;
            x_q <= '0;
            y_q <= '0;
            colour_q <= '0;
            en_q <= 1'b0;
            as_q <= '0;
            idle_done_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            x_q <= x_d;
            y_q <= y_d;
            colour_q <= colour_d;
            en_q <= en_d;
            as_q <= as_d;
            idle_done_q <= idle_done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.x_position    = x_q;
    assign bus.y_position    = y_q;
    assign bus.colour        = colour_q;
    assign bus.VGA_enable    = en_q;
    assign bus.active_src    = as_q;
    assign bus.idle_done     = idle_done_q;
    assign bus.frame_overrun = overrun_q;

`ifdef DRAW_SEQ_STATS_EN
    logic [15:0] miss_q, miss_d;
    assign miss_d = bus.init ? '0 : (overrun_d && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
    always_ff @(posedge clock) begin
        if (reset) miss_q <= '0;
        else miss_q <= miss_d;
    end
    assign bus.frame_miss_count = miss_q;
`else
    assign bus.frame_miss_count = '0;
`endif
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed checks of pixel mux, frame pacing, init and reset
module tb_draw_sequencer;
    logic clock = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_bad = 0;

    draw_seq_if #(.NUM_SRC(3), .X_W(9), .Y_W(8), .COLOUR_W(6)) bus ();

    draw_sequencer #(
        .NUM_SRC(3), .X_W(9), .Y_W(8), .COLOUR_W(6), .FRAME_COUNT(8), .CNT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

`ifdef DRAW_SEQ_STATS_EN
    localparam int MISS_EXP = 1;
`else
    localparam int MISS_EXP = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input int c,
                             input int en, input int as);
        check({tag, ".x"}, 32'(bus.x_position), 32'(x));
        check({tag, ".y"}, 32'(bus.y_position), 32'(y));
        check({tag, ".colour"}, 32'(bus.colour), 32'(c));
        check({tag, ".en"}, 32'(bus.VGA_enable), 32'(en));
        check({tag, ".as"}, 32'(bus.active_src), 32'(as));
    endtask

    initial begin
        reset = 1'b1;
        bus.init = 1'b0;
        bus.idle = 1'b1;
        bus.src_draw = '0;
        bus.src_done = '0;
        bus.src_write = '0;
        bus.src_x = '0;
        bus.src_y = '0;
        bus.src_colour = '0;
        step();
        step();
        check_pix("reset", 0, 0, 0, 0, 0);
        check("reset.idle_done", 32'(bus.idle_done), 0);
        check("reset.overrun", 32'(bus.frame_overrun), 0);
        check("reset.miss", 32'(bus.frame_miss_count), 0);
        reset = 1'b0;

        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("idle_done.c%0d", k), 32'(bus.idle_done), 32'(k % 8 == 0));
            check($sformatf("overrun.c%0d", k), 32'(bus.frame_overrun), 0);
        end

        bus.src_x = {9'd100, 9'd9, 9'd5};
        bus.src_y = {8'd200, 8'd2, 8'd7};
        bus.src_colour = {6'h2A, 6'h11, 6'h3F};
        bus.src_write = 3'b011;
        bus.src_draw = 3'b111;
        step();
        check_pix("ch0", 5, 7, 'h3F, 1, 0);
        bus.src_done = 3'b001;
        step();
        check_pix("ch1", 9, 2, 'h11, 1, 1);
        bus.src_done = 3'b011;
        step();
        check_pix("ch2", 100, 200, 'h2A, 0, 2);
        bus.src_done = 3'b111;
        step();
        check_pix("all_done", 0, 0, 0, 0, 0);
        bus.src_done = 3'b000;
        bus.src_draw = 3'b110;
        step();
        check_pix("draw110", 9, 2, 'h11, 1, 1);
        bus.src_draw = 3'b000;
        step();
        check_pix("no_draw", 0, 0, 0, 0, 0);

        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
        check("init.idle_done", 32'(bus.idle_done), 0);
        for (int k = 0; k < 5; k++) step();
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("init_idle_done.c%0d", k), 32'(bus.idle_done), 32'(k == 8));
        end

        bus.idle = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            check($sformatf("overrun.j%0d", j), 32'(bus.frame_overrun), 32'(j == 16));
            check($sformatf("pend_idle_done.j%0d", j), 32'(bus.idle_done), 0);
        end
        bus.idle = 1'b1;
        step();
        check("pend_release.idle_done", 32'(bus.idle_done), 1);
        check("pend_release.overrun", 32'(bus.frame_overrun), 0);
        check("miss_count", 32'(bus.frame_miss_count), 32'(MISS_EXP));
        step();
        check("pend_release.width", 32'(bus.idle_done), 0);

        bus.idle = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.idle = 1'b1;
        check("rst_pend.miss", 32'(bus.frame_miss_count), 0);
        check("rst_pend.idle_done", 32'(bus.idle_done), 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("rst_pend_idle_done.c%0d", k), 32'(bus.idle_done), 32'(k == 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
